// File: rtl/cfg_pkg.sv
// Shared encodings and sizing for the config burst sequencer: FSM states,
// target module codes and the legal word count of each target SRAM.
package cfg_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned SEL_W  = 8;
  localparam int unsigned MOD_W  = 2;

  localparam logic [MOD_W-1:0] MOD_IBF_NET = 2'd0;
  localparam logic [MOD_W-1:0] MOD_IBF_MUX = 2'd1;
  localparam logic [MOD_W-1:0] MOD_BV      = 2'd2;
  localparam logic [MOD_W-1:0] MOD_BF      = 2'd3;

  localparam int unsigned IBF_NET_DEPTH_DEF = 3;
  localparam int unsigned IBF_MUX_DEPTH_DEF = 1;
  localparam int unsigned BV_DEPTH_DEF      = 64;
  localparam int unsigned BF_DEPTH_DEF      = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/cfg_burst_sequencer_if.sv
// Command, write-data and config-bus signals of the burst sequencer.
// master = command/data source and config-bus observer, slave = sequencer.
interface cfg_burst_sequencer_if;
  import cfg_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [MOD_W-1:0]  cmd_module;
  logic [SEL_W-1:0]  cmd_sram_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic [MOD_W-1:0]  cfg_sel_module;
  logic [SEL_W-1:0]  cfg_sram_sel;
  logic [ADDR_W-1:0] cfg_addr_write;
  logic              cfg_wr_en;
  logic [DATA_W-1:0] cfg_data;

  modport master (
    output cmd_valid, cmd_module, cmd_sram_sel, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    input  cmd_ready, wdata_ready,
    input  cfg_sel_module, cfg_sram_sel, cfg_addr_write, cfg_wr_en, cfg_data
  );

  modport slave (
    input  cmd_valid, cmd_module, cmd_sram_sel, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    output cmd_ready, wdata_ready,
    output cfg_sel_module, cfg_sram_sel, cfg_addr_write, cfg_wr_en, cfg_data
  );

endinterface

// File: rtl/cfg_drain_counter.sv
// Counts consecutive idle datapath cycles while enabled and flags the cycle
// on which the run reaches DRAIN_CYCLES; any busy cycle restarts the run.
module cfg_drain_counter #(
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic dval_i,
  output logic done_o
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A zero-length drain still spends its one enabled cycle here.
  always_comb begin
    cnt_d  = '0;
    done_o = 1'b0;
    if (en_i) begin
      if (!dval_i) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      done_o = (DRAIN_CYCLES == 0) || (cnt_d == CNT_W'(DRAIN_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cfg_burst_sequencer.sv
// Config burst sequencer: validates a burst command, holds off and drains the
// datapath, then streams config words onto the bus at incrementing addresses.
module cfg_burst_sequencer
  import cfg_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 16,
  parameter int unsigned IBF_NET_DEPTH = IBF_NET_DEPTH_DEF,
  parameter int unsigned IBF_MUX_DEPTH = IBF_MUX_DEPTH_DEF,
  parameter int unsigned BV_DEPTH      = BV_DEPTH_DEF,
  parameter int unsigned BF_DEPTH      = BF_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  cfg_burst_sequencer_if.slave  bus,
  input  logic                  dval_i,
  output logic                  hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned END_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              cfg_wr_en_q, cfg_wr_en_d;
  logic [MOD_W-1:0]  cfg_mod_q, cfg_mod_d;
  logic [SEL_W-1:0]  cfg_sel_q, cfg_sel_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;

  logic             cmd_hs;
  logic             wd_hs;
  logic             cmd_legal;
  logic             drain_done;
  logic [END_W-1:0] cmd_end;

  function automatic logic [END_W-1:0] target_depth(input logic [MOD_W-1:0] m);
    case (m)
      MOD_IBF_NET: target_depth = END_W'(IBF_NET_DEPTH);
      MOD_IBF_MUX: target_depth = END_W'(IBF_MUX_DEPTH);
      MOD_BV:      target_depth = END_W'(BV_DEPTH);
      default:     target_depth = END_W'(BF_DEPTH);
    endcase
  endfunction

  // One extra bit so addr+len cannot wrap back into the legal range.
  assign cmd_end   = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign cmd_legal = (bus.cmd_len != '0) && (cmd_end <= target_depth(bus.cmd_module));

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.wdata_ready = (state_q == ST_WRITE);
  assign cmd_hs          = bus.cmd_valid && bus.cmd_ready;
  assign wd_hs           = bus.wdata_valid && bus.wdata_ready;

  assign hold_o = (state_q == ST_DRAIN) || (state_q == ST_WRITE) || (state_q == ST_DONE);
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = (state_q == ST_ERR);

  assign bus.cfg_wr_en      = cfg_wr_en_q;
  assign bus.cfg_sel_module = cfg_mod_q;
  assign bus.cfg_sram_sel   = cfg_sel_q;
  assign bus.cfg_addr_write = cfg_addr_q;
  assign bus.cfg_data       = cfg_data_q;

  cfg_drain_counter #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_drain (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_DRAIN),
    .dval_i (dval_i),
    .done_o (drain_done)
  );

  always_comb begin
    state_d     = state_q;
    mod_d       = mod_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cfg_wr_en_d = 1'b0;
    cfg_mod_d   = cfg_mod_q;
    cfg_sel_d   = cfg_sel_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          mod_d   = bus.cmd_module;
          sel_d   = bus.cmd_sram_sel;
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          state_d = cmd_legal ? ST_DRAIN : ST_ERR;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_WRITE;
        end
      end
      // dval_i is deliberately not looked at here: writes never stall on it.
      ST_WRITE: begin
        if (wd_hs) begin
          cfg_wr_en_d = 1'b1;
          cfg_mod_d   = mod_q;
          cfg_sel_d   = sel_q;
          cfg_addr_d  = addr_q;
          cfg_data_d  = bus.wdata;
          addr_d      = addr_q + ADDR_W'(1);
          len_d       = len_q - ADDR_W'(1);
          if (len_q == ADDR_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mod_q       <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cfg_wr_en_q <= 1'b0;
      cfg_mod_q   <= '0;
      cfg_sel_q   <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mod_q       <= mod_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cfg_wr_en_q <= cfg_wr_en_d;
      cfg_mod_q   <= cfg_mod_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

endmodule
